// File: rtl/md_bus_monitor.sv
// MD bus monitor: synchronises the cartridge strobes, turns each /AS cycle into one rd/wr pulse
// and queues TIM-region writes. Define MDMON_TIM_FIFO_EN for a FIFO_DEPTH-deep TIM queue.

module md_sync_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, meta} <= 2'b11;
    else      {q, meta} <= {meta, d};
endmodule

module md_bus_monitor #(
  parameter int SETTLE     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        as,
  input  logic        oe,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic        ce_hi,
  input  logic        tim,
  input  logic [23:1] addr,
  input  logic [15:0] data,
  output logic        rd_req,
  output logic        wr_req,
  output logic [1:0]  wr_be,
  output logic [23:1] cyc_addr,
  output logic [15:0] cyc_data,
  output logic        cyc_rom,
  output logic        tim_valid,
  input  logic        tim_ready,
  output logic [6:0]  tim_addr,
  output logic [15:0] tim_data,
  output logic [1:0]  tim_be,
  output logic        tim_ovf,
  input  logic        tim_ovf_clr
);
  localparam logic [3:0] CNT_MAX = 4'(SETTLE - 1);
  localparam int NSYNC = 6;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  logic [NSYNC-1:0] raw, syn;
  assign raw = {tim, ce_hi, we_hi, we_lo, oe, as};

  for (genvar g = 0; g < NSYNC; g++) begin : g_sync
    md_sync_cell u_sync (.clk(clk), .rst(rst), .d(raw[g]), .q(syn[g]));
  end

  logic as_s, oe_s, we_lo_s, we_hi_s, ce_hi_s, tim_s;
  assign {tim_s, ce_hi_s, we_hi_s, we_lo_s, oe_s, as_s} = syn;

  state_t     state;
  logic [3:0] cnt, cnt_nxt;
  logic       as_prev, armed;
  logic [1:0] prime;
  logic       fall, do_rd, do_wr, cap, push, pop, full, empty, push_ok;
  logic [24:0] entry, head;

  // armed only once a post-reset pin sample of /AS has been seen high
  assign fall  = armed & as_prev & ~as_s;
  assign do_rd = ~oe_s;
  assign do_wr = ~we_lo_s | ~we_hi_s;

  always_comb begin
    cnt_nxt = 4'd0;
    if (state == WAIT) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
  end

  // decided one edge early so the registered pulse lands in the cycle the counter reaches SETTLE-1
  assign cap = ~as_s & (do_rd | do_wr) & (cnt_nxt == CNT_MAX) &
               (((state == IDLE) & fall) | (state == WAIT));

  assign entry   = {addr[7:1], data, ~we_hi_s, ~we_lo_s};
  assign push    = cap & do_wr & ~tim_s;
  assign pop     = tim_valid & tim_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      as_prev  <= 1'b1;
      armed    <= 1'b0;
      prime    <= 2'b00;
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      wr_be    <= 2'b00;
      cyc_addr <= '0;
      cyc_data <= '0;
      cyc_rom  <= 1'b0;
    end else begin
      prime   <= {prime[0], 1'b1};
      as_prev <= as_s;
      if (prime[1] & as_s) armed <= 1'b1;
      rd_req <= 1'b0;
      wr_req <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          cnt   <= 4'd0;
          state <= cap ? HOLD : WAIT;
        end
        WAIT: if (as_s) state <= IDLE;
              else begin
                cnt <= cnt_nxt;
                if (cap) state <= HOLD;
              end
        HOLD: if (as_s) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (cap) begin
        cyc_addr <= addr;
        cyc_data <= data;
        cyc_rom  <= ~ce_hi_s;
        if (do_wr) begin
          wr_req <= 1'b1;
          wr_be  <= {~we_hi_s, ~we_lo_s};
        end else begin
          rd_req <= 1'b1;
        end
      end
    end
  end

`ifdef MDMON_TIM_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PONE = 1;
  logic [24:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk)
    if (push_ok) mem[wp[AW-1:0]] <= entry;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + PONE;
      if (pop)     rp <= rp + PONE;
    end
`else
  logic [24:0] hreg;
  logic        hv;
  logic        unused_depth;
  assign unused_depth = (FIFO_DEPTH > 0);

  assign empty = ~hv;
  assign full  = hv;
  assign head  = hreg;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hreg <= '0;
      hv   <= 1'b0;
    end else if (push_ok) begin
      hreg <= entry;
      hv   <= 1'b1;
    end else if (pop) begin
      hv   <= 1'b0;
    end
`endif

  assign tim_valid = ~empty;
  assign {tim_addr, tim_data, tim_be} = tim_valid ? head : 25'd0;

  // an overflowing push beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) tim_ovf <= 1'b0;
    else      tim_ovf <= (push & full & ~pop) | (tim_ovf & ~tim_ovf_clr);
endmodule

// File: doc/md_bus_monitor.md
MD_BUS_MONITOR -- requirements
Module: md_bus_monitor

Interface
REQ-001 SHALL have parameter SETTLE, default 3; clk cycles after synced /AS fall before addr/data are sampled (legal 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8; depth of the TIM write queue (power of 2, 2..16).
REQ-003 SHALL have port clk, input, 1; sole clock (50 MHz system clock).
REQ-004 SHALL have port rst, input, 1; reset, asynchronous, active-low.
REQ-005 SHALL have ports as, oe, we_lo, we_hi, ce_hi, tim, each an input of width 1; MD bus strobes, active-low and asynchronous to clk.
REQ-006 SHALL have port addr, input, 23 [23:1]; MD address bus.
REQ-007 SHALL have port data, input, 16; MD data bus.
REQ-008 SHALL have ports rd_req and wr_req, each an output of width 1; one-cycle bus-event pulses.
REQ-009 SHALL have port wr_be, output, 2 {hi,lo}; write byte enables, valid with wr_req.
REQ-010 SHALL have ports cyc_addr (output, 23), cyc_data (output, 16) and cyc_rom (output, 1); captured cycle fields, with cyc_rom = ROM region (ce_hi low).
REQ-011 SHALL have ports tim_valid (output, 1) and tim_ready (input, 1); TIM queue handshake.
REQ-012 SHALL have ports tim_addr (output, 7, addr[7:1]), tim_data (output, 16) and tim_be (output, 2); head-of-queue entry.
REQ-013 SHALL have ports tim_ovf (output, 1, sticky overflow) and tim_ovf_clr (input, 1, clear strobe).

Function
REQ-014 SHALL pass as, oe, we_lo, we_hi, ce_hi and tim through 2-flop synchronisers before any use; addr and data SHALL be sampled unsynchronised, only at the capture point.
REQ-015 SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-016 IDLE->WAIT on synced as low with previous synced as high; the settle counter SHALL clear to 0.
REQ-017 In WAIT the counter SHALL increment and saturate at SETTLE-1; capture SHALL occur on the first cycle with counter==SETTLE-1 and synced oe or any synced we low.
REQ-018 Capture SHALL latch cyc_addr, cyc_data and cyc_rom, and SHALL go to HOLD.
REQ-019 At capture: oe low SHALL give rd_req=1 for one cycle; any we low SHALL give wr_req=1 for one cycle with wr_be={!we_hi_s,!we_lo_s}; if oe and we are both low, write SHALL take priority.
REQ-020 Synced as high while in WAIT SHALL return the FSM to IDLE with no pulse (aborted cycle).
REQ-021 HOLD->IDLE on synced as high; no further pulses SHALL be issued within one /AS assertion.
REQ-022 Latency SHALL be: rd_req/wr_req asserted exactly SETTLE cycles after the first cycle in which synced as is low (2+SETTLE+1 cycles worst case from the pin).
REQ-023 A capture with wr_req and synced tim low SHALL push {addr[7:1], data, be} into the queue in the same cycle.
REQ-024 tim_valid SHALL equal queue not empty; a pop SHALL occur when tim_valid & tim_ready; FIFO order SHALL be preserved.
REQ-025 Push while full without pop SHALL drop the entry and set tim_ovf; push and pop in the same cycle while full SHALL both succeed without overflow.
REQ-026 tim_ovf SHALL clear on tim_ovf_clr; set SHALL win over clear in the same cycle.
REQ-027 cyc_* outputs SHALL hold their value until the next capture.

Reset
REQ-028 While rst is low: all outputs 0, FSM IDLE, counter 0, queue empty, tim_ovf 0, synchroniser flops 1 (inactive).
REQ-029 After rst release, the FSM SHALL ignore bus activity until synced as has been observed high at least once, so a cycle in progress at release SHALL produce no pulse.

Configuration
REQ-030 With macro MDMON_TIM_FIFO_EN defined, the queue SHALL be FIFO_DEPTH entries deep.
REQ-031 With MDMON_TIM_FIFO_EN undefined, the queue SHALL be a single-entry register with identical handshake and overflow rules (full = valid), and FIFO_DEPTH SHALL be ignored.

Verification
REQ-032 Read at addr 0x000200 (word), ce_hi low, SETTLE=3 -> one rd_req pulse 3 cycles after as_s falls, cyc_addr=0x000100, cyc_rom=1, wr_req never set.
REQ-033 Write 0xA5A5 to 0xA13010 with we_lo only, tim low -> wr_req, wr_be=2'b01, tim_valid=1, tim_addr=0x08, tim_data=0xA5A5, tim_be=2'b01.
REQ-034 /AS pulse of 2 cycles with SETTLE=3 -> no pulse, FSM returns to IDLE, cyc_* unchanged.
REQ-035 9 TIM writes with tim_ready=0 (FIFO_EN, depth 8) -> 8 entries popped in order afterwards, tim_ovf=1; 9th write with simultaneous pop -> no overflow.
REQ-036 rst pulsed low while as held low, then released -> no pulse until as rises and falls again; outputs 0 during reset.
REQ-037 tim_ovf_clr in the same cycle as an overflowing push -> tim_ovf stays 1; a later clear alone -> 0.
